// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and defaults for the scoreboard-based hazard unit.
package hazard_scoreboard_pkg;

  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned RA_W_DEF   = 5;
  localparam int unsigned LAT_W_DEF  = 4;
  localparam int unsigned PERF_W_DEF = 32;
  localparam int unsigned FSEL_W     = 2;

  // Default producer latencies (issue to E-forwardable).
  localparam int unsigned ALU_LAT  = 1;
  localparam int unsigned LOAD_LAT = 2;

  // E-stage operand source select.
  typedef enum logic [FSEL_W-1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // M beats W: it holds the younger value of the register.
  function automatic fwd_sel_e fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m) begin
      return FWD_M;
    end else if (hit_w) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard-unit signal bundle.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
);

  logic              issue_valid_d;
  logic [RA_W-1:0]   rs1_d;
  logic [RA_W-1:0]   rs2_d;
  logic              use_rs1_d;
  logic              use_rs2_d;
  logic [RA_W-1:0]   rd_d;
  logic              we_d;
  logic [LAT_W-1:0]  lat_d;
  logic              long_op_d;
  logic              lou_busy;
  logic              pc_src_e;
  logic [RA_W-1:0]   rs1_e;
  logic [RA_W-1:0]   rs2_e;
  logic [RA_W-1:0]   rd_m;
  logic [RA_W-1:0]   rd_w;
  logic              we_m;
  logic              we_w;

  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [FSEL_W-1:0] fwd_a_e;
  logic [FSEL_W-1:0] fwd_b_e;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output issue_valid_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, we_d, lat_d,
           long_op_d, lou_busy, pc_src_e, rs1_e, rs2_e, rd_m, rd_w, we_m, we_w,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt
  );

  modport slave (
    input  issue_valid_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, we_d, lat_d,
           long_op_d, lou_busy, pc_src_e, rs1_e, rs2_e, rd_m, rd_w, we_m, we_w,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt
  );

endinterface

// File: rtl/sb_timer.sv
// Per-register pending timer: load on issue, otherwise count down to zero and hold.
module sb_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt
);

  // A load wins over the decrement so the newest producer's latency sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register latency timers drive D-stage stalls,
// branch flushes and the E-stage forwarding selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter int unsigned LAT_W  = LAT_W_DEF,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned    LAT_X_W = LAT_W + 1;
  localparam logic [LAT_W-1:0]  LAT_MAX = '1;
  localparam logic [PERF_W-1:0] CNT_MAX = '1;

  logic [LAT_W-1:0]   pend [NREGS];
  logic [LAT_W-1:0]   lat_base;
  logic [LAT_X_W-1:0] lat_ext;
  logic [LAT_W-1:0]   eff_lat;
  logic               busy_rs1;
  logic               busy_rs2;
  logic               raw_haz;
  logic               str_haz;
  logic               hold;
  logic               issue;
  logic               wr_en;
  fwd_sel_e           fwd_a;
  fwd_sel_e           fwd_b;
  logic [PERF_W-1:0]  stall_cnt_q;

  // x0 is hardwired ready.
  assign pend[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_timer
    sb_timer #(.W(LAT_W)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (wr_en && (bus.rd_d == RA_W'(r))),
      .val  (eff_lat),
      .cnt  (pend[r])
    );
  end

  // Latency to load: zero means one; without forwarding wait two more for RF write-through.
  always_comb begin
    lat_base = (bus.lat_d == '0) ? LAT_W'(1) : bus.lat_d;
    lat_ext  = LAT_X_W'(lat_base) + LAT_X_W'(2);
    eff_lat  = lat_base;
    if (FWD_EN == 0) begin
      eff_lat = (lat_ext > LAT_X_W'(LAT_MAX)) ? LAT_MAX : lat_ext[LAT_W-1:0];
    end
  end

  // Hazard decision; a timer at 1 is already forwardable so only >=2 blocks.
  always_comb begin
    busy_rs1 = bus.use_rs1_d && (bus.rs1_d != '0) && (pend[bus.rs1_d] >= LAT_W'(2));
    busy_rs2 = bus.use_rs2_d && (bus.rs2_d != '0) && (pend[bus.rs2_d] >= LAT_W'(2));
    raw_haz  = bus.issue_valid_d && (busy_rs1 || busy_rs2);
    str_haz  = bus.issue_valid_d && bus.long_op_d && bus.lou_busy;
    hold     = (raw_haz || str_haz) && !bus.pc_src_e;
    issue    = bus.issue_valid_d && !hold && !bus.pc_src_e;
    wr_en    = issue && bus.we_d && (bus.rd_d != '0);
  end

  // E-stage operand selects.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN != 0) begin
      fwd_a = fwd_pick((bus.rs1_e != '0) && bus.we_m && (bus.rd_m == bus.rs1_e),
                       (bus.rs1_e != '0) && bus.we_w && (bus.rd_w == bus.rs1_e));
      fwd_b = fwd_pick((bus.rs2_e != '0) && bus.we_m && (bus.rd_m == bus.rs2_e),
                       (bus.rs2_e != '0) && bus.we_w && (bus.rd_w == bus.rs2_e));
    end
  end

  // Pipeline control; reset pins the pipe in a flushed, unstalled state.
  always_comb begin
    bus.stall_f = 1'b0;
    bus.stall_d = 1'b0;
    bus.flush_d = 1'b1;
    bus.flush_e = 1'b1;
    bus.fwd_a_e = FWD_RF;
    bus.fwd_b_e = FWD_RF;
    if (!rst) begin
      bus.stall_f = hold;
      bus.stall_d = hold;
      bus.flush_d = bus.pc_src_e;
      bus.flush_e = hold || bus.pc_src_e;
      bus.fwd_a_e = fwd_a;
      bus.fwd_b_e = fwd_b;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hold && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: FWD_EN=1 and FWD_EN=0 instances share stimulus;
// a behavioural scoreboard model checks both every cycle, directed scenarios pin it.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RA_W(5), .LAT_W(4), .PERF_W(32)) bus1 ();
  hazard_scoreboard_if #(.RA_W(5), .LAT_W(4), .PERF_W(32)) bus0 ();

  assign bus0.issue_valid_d = bus1.issue_valid_d;
  assign bus0.rs1_d         = bus1.rs1_d;
  assign bus0.rs2_d         = bus1.rs2_d;
  assign bus0.use_rs1_d     = bus1.use_rs1_d;
  assign bus0.use_rs2_d     = bus1.use_rs2_d;
  assign bus0.rd_d          = bus1.rd_d;
  assign bus0.we_d          = bus1.we_d;
  assign bus0.lat_d         = bus1.lat_d;
  assign bus0.long_op_d     = bus1.long_op_d;
  assign bus0.lou_busy      = bus1.lou_busy;
  assign bus0.pc_src_e      = bus1.pc_src_e;
  assign bus0.rs1_e         = bus1.rs1_e;
  assign bus0.rs2_e         = bus1.rs2_e;
  assign bus0.rd_m          = bus1.rd_m;
  assign bus0.rd_w          = bus1.rd_w;
  assign bus0.we_m          = bus1.we_m;
  assign bus0.we_w          = bus1.we_w;

  hazard_scoreboard #(.NREGS(32), .RA_W(5), .LAT_W(4), .FWD_EN(1), .PERF_W(32)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  hazard_scoreboard #(.NREGS(32), .RA_W(5), .LAT_W(4), .FWD_EN(0), .PERF_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL fwd_en%0d %s: got %0d, want %0d (t=%0t)", m, name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     pend_m [2][32];
  longint cnt_m  [2];

  function automatic int eff_of(input int fwd, input int lat);
    int l;
    l = (lat == 0) ? 1 : lat;
    if (fwd == 0) l = (l + 2 > 15) ? 15 : l + 2;
    return l;
  endfunction

  function automatic int fwd_exp(input int fwd, input int rs, input int wm, input int rm,
                                 input int ww, input int rw);
    if (fwd == 0 || rs == 0) return 0;
    if (wm != 0 && rm == rs) return 2;
    if (ww != 0 && rw == rs) return 1;
    return 0;
  endfunction

  // Per-cycle compare of both instances, then advance the model to the next edge.
  initial begin
    logic a_sf, a_sd, a_fd, a_fe;
    logic [1:0] a_fa, a_fb;
    logic [31:0] a_cnt;
    int v, hold, raw, str, pc, fwd, issue;
    for (int m = 0; m < 2; m++) begin
      cnt_m[m] = 0;
      for (int r = 0; r < 32; r++) pend_m[m][r] = 0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        fwd = m;
        if (m == 1) begin
          a_sf = bus1.stall_f; a_sd = bus1.stall_d; a_fd = bus1.flush_d; a_fe = bus1.flush_e;
          a_fa = bus1.fwd_a_e; a_fb = bus1.fwd_b_e; a_cnt = bus1.stall_cnt;
        end else begin
          a_sf = bus0.stall_f; a_sd = bus0.stall_d; a_fd = bus0.flush_d; a_fe = bus0.flush_e;
          a_fa = bus0.fwd_a_e; a_fb = bus0.fwd_b_e; a_cnt = bus0.stall_cnt;
        end
        v   = int'(bus1.issue_valid_d);
        pc  = int'(bus1.pc_src_e);
        raw = v & ((bus1.use_rs1_d && bus1.rs1_d != 0 && pend_m[m][bus1.rs1_d] >= 2) ||
                   (bus1.use_rs2_d && bus1.rs2_d != 0 && pend_m[m][bus1.rs2_d] >= 2) ? 1 : 0);
        str = (v != 0 && bus1.long_op_d && bus1.lou_busy) ? 1 : 0;
        hold = ((raw | str) != 0 && pc == 0) ? 1 : 0;
        if (rst) begin
          chk("stall_f", m, 32'(a_sf), 0);
          chk("stall_d", m, 32'(a_sd), 0);
          chk("flush_d", m, 32'(a_fd), 1);
          chk("flush_e", m, 32'(a_fe), 1);
          chk("fwd_a_e", m, 32'(a_fa), 0);
          chk("fwd_b_e", m, 32'(a_fb), 0);
        end else begin
          chk("stall_f", m, 32'(a_sf), 32'(hold));
          chk("stall_d", m, 32'(a_sd), 32'(hold));
          chk("flush_d", m, 32'(a_fd), 32'(pc));
          chk("flush_e", m, 32'(a_fe), 32'((hold != 0 || pc != 0) ? 1 : 0));
          chk("fwd_a_e", m, 32'(a_fa), 32'(fwd_exp(fwd, int'(bus1.rs1_e), int'(bus1.we_m),
                                        int'(bus1.rd_m), int'(bus1.we_w), int'(bus1.rd_w))));
          chk("fwd_b_e", m, 32'(a_fb), 32'(fwd_exp(fwd, int'(bus1.rs2_e), int'(bus1.we_m),
                                        int'(bus1.rd_m), int'(bus1.we_w), int'(bus1.rd_w))));
        end
        chk("stall_cnt", m, a_cnt, 32'(cnt_m[m]));
        // next edge
        if (rst) begin
          cnt_m[m] = 0;
          for (int r = 0; r < 32; r++) pend_m[m][r] = 0;
        end else begin
          issue = (v != 0 && hold == 0 && pc == 0) ? 1 : 0;
          for (int r = 1; r < 32; r++) if (pend_m[m][r] > 0) pend_m[m][r] = pend_m[m][r] - 1;
          if (issue != 0 && bus1.we_d && bus1.rd_d != 0)
            pend_m[m][bus1.rd_d] = eff_of(fwd, int'(bus1.lat_d));
          if (hold != 0 && cnt_m[m] < 64'd4294967295) cnt_m[m] = cnt_m[m] + 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus1.issue_valid_d = 0; bus1.rs1_d = 0; bus1.rs2_d = 0; bus1.use_rs1_d = 0;
    bus1.use_rs2_d = 0; bus1.rd_d = 0; bus1.we_d = 0; bus1.lat_d = 0; bus1.long_op_d = 0;
    bus1.lou_busy = 0; bus1.pc_src_e = 0; bus1.rs1_e = 0; bus1.rs2_e = 0; bus1.rd_m = 0;
    bus1.rd_w = 0; bus1.we_m = 0; bus1.we_w = 0;
  endtask

  task automatic set_d(input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int we, input int lat, input int lo);
    bus1.issue_valid_d = 1;
    bus1.rs1_d = 5'(rs1); bus1.use_rs1_d = u1[0];
    bus1.rs2_d = 5'(rs2); bus1.use_rs2_d = u2[0];
    bus1.rd_d = 5'(rd); bus1.we_d = we[0]; bus1.lat_d = 4'(lat); bus1.long_op_d = lo[0];
  endtask

  task automatic do_reset();
    rst = 1; idle_in(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();
    @(posedge clk); #1;
    set_d(5, 1, 6, 1, 7, 1, 1, 0);
    #2;
    chk("rst stall_d forced", 1, 32'(bus1.stall_d), 0);
    chk("rst flush_d forced", 1, 32'(bus1.flush_d), 1);
    chk("rst flush_e forced", 0, 32'(bus0.flush_e), 1);
    chk("rst stall_cnt", 1, bus1.stall_cnt, 0);
    tick();
    rst = 0;

    // 1: ALU back-to-back
    idle_in(); set_d(0, 0, 0, 0, 5, 1, 1, 0); #2;
    chk("s1 producer stall_d", 1, 32'(bus1.stall_d), 0);
    tick();
    set_d(5, 1, 0, 0, 6, 1, 1, 0); #2;
    chk("s1 consumer stall_d", 1, 32'(bus1.stall_d), 0);
    chk("s1 consumer stall_d", 0, 32'(bus0.stall_d), 1);
    tick();
    idle_in(); bus1.rs1_e = 5; bus1.rd_m = 5; bus1.we_m = 1; #2;
    chk("s1 fwd_a_e", 1, 32'(bus1.fwd_a_e), 2);
    chk("s1 fwd_a_e", 0, 32'(bus0.fwd_a_e), 0);
    tick();
    do_reset();

    // 2: load-use
    set_d(0, 0, 0, 0, 5, 1, 2, 0); tick();
    set_d(5, 1, 0, 0, 6, 1, 1, 0); #2;
    chk("s2 stall_d", 1, 32'(bus1.stall_d), 1);
    chk("s2 stall_f", 1, 32'(bus1.stall_f), 1);
    chk("s2 flush_e", 1, 32'(bus1.flush_e), 1);
    chk("s2 flush_d", 1, 32'(bus1.flush_d), 0);
    tick(); #2;
    chk("s2 release", 1, 32'(bus1.stall_d), 0);
    chk("s2 still", 0, 32'(bus0.stall_d), 1);
    tick();
    bus1.rs1_e = 5; bus1.rd_m = 5; bus1.we_m = 1; #2;
    chk("s2 fwd_a_e M", 1, 32'(bus1.fwd_a_e), 2);
    tick();
    bus1.rs2_e = 5; bus1.rd_m = 0; bus1.we_m = 0; bus1.rd_w = 5; bus1.we_w = 1; #2;
    chk("s2 fwd_b_e W", 1, 32'(bus1.fwd_b_e), 1);
    chk("s2 nofwd release", 0, 32'(bus0.stall_d), 0);
    tick();
    idle_in(); bus1.rs1_e = 5; bus1.rd_m = 5; bus1.we_m = 1; bus1.rd_w = 5; bus1.we_w = 1; #2;
    chk("s2 M over W", 1, 32'(bus1.fwd_a_e), 2);
    chk("s2 stall_cnt", 1, bus1.stall_cnt, 1);
    chk("s2 stall_cnt", 0, bus0.stall_cnt, 3);
    tick();
    idle_in(); bus1.rs1_e = 0; bus1.rd_m = 0; bus1.we_m = 1; #2;
    chk("s2 x0 no fwd", 1, 32'(bus1.fwd_a_e), 0);
    tick();
    do_reset();

    // 3: MUL latency 4, then independent instruction
    set_d(0, 0, 0, 0, 7, 1, 4, 0); tick();
    set_d(7, 1, 0, 0, 8, 1, 1, 0); #2;
    chk("s3 stall_d", 1, 32'(bus1.stall_d), 1);
    repeat (5) tick();
    idle_in(); #2;
    chk("s3 stall_cnt", 1, bus1.stall_cnt, 3);
    chk("s3 stall_cnt", 0, bus0.stall_cnt, 5);
    tick();
    do_reset();
    set_d(0, 0, 0, 0, 7, 1, 4, 0); tick();
    set_d(3, 1, 4, 1, 9, 1, 1, 0); #2;
    chk("s3 indep stall_d", 1, 32'(bus1.stall_d), 0);
    chk("s3 indep stall_d", 0, 32'(bus0.stall_d), 0);
    tick();
    do_reset();

    // 4: branch flush beats stall, timer keeps counting
    set_d(0, 0, 0, 0, 7, 1, 4, 0); tick();
    set_d(7, 1, 0, 0, 8, 1, 1, 0); bus1.pc_src_e = 1; #2;
    chk("s4 stall_d", 1, 32'(bus1.stall_d), 0);
    chk("s4 stall_f", 1, 32'(bus1.stall_f), 0);
    chk("s4 flush_d", 1, 32'(bus1.flush_d), 1);
    chk("s4 flush_e", 1, 32'(bus1.flush_e), 1);
    tick();
    bus1.pc_src_e = 0; #2;
    chk("s4 stall after", 1, 32'(bus1.stall_d), 1);
    tick(); tick(); #2;
    chk("s4 release", 1, 32'(bus1.stall_d), 0);
    chk("s4 stall_cnt", 1, bus1.stall_cnt, 2);
    tick();
    do_reset();

    // 5: long-op unit busy
    set_d(0, 0, 0, 0, 0, 0, 1, 1); bus1.lou_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #2; chk("s5 stall_d", 1, 32'(bus1.stall_d), 1);
      tick();
    end
    bus1.lou_busy = 0; #2;
    chk("s5 issue", 1, 32'(bus1.stall_d), 0);
    chk("s5 stall_cnt", 1, bus1.stall_cnt, 5);
    chk("s5 stall_cnt", 0, bus0.stall_cnt, 5);
    tick();
    do_reset();

    // 6: reset mid-operation
    set_d(0, 0, 0, 0, 5, 1, 4, 0); tick();
    idle_in(); tick();
    rst = 1; set_d(5, 1, 0, 0, 6, 1, 1, 0); #2;
    chk("s6 rst stall_d", 1, 32'(bus1.stall_d), 0);
    chk("s6 rst flush_d", 1, 32'(bus1.flush_d), 1);
    tick();
    rst = 0; #2;
    chk("s6 post-rst stall_d", 1, 32'(bus1.stall_d), 0);
    chk("s6 post-rst stall_d", 0, 32'(bus0.stall_d), 0);
    chk("s6 stall_cnt", 1, bus1.stall_cnt, 0);
    tick();
    do_reset();

    // WAW: newest latency wins; lat 0 acts as 1
    set_d(0, 0, 0, 0, 5, 1, 9, 0); tick();
    set_d(0, 0, 0, 0, 5, 1, 1, 0); tick();
    set_d(0, 5, 5, 1, 6, 1, 1, 0); #2;
    chk("waw stall_d", 1, 32'(bus1.stall_d), 0);
    tick();
    do_reset();
    set_d(0, 0, 0, 0, 5, 1, 0, 0); tick();
    set_d(5, 1, 0, 0, 6, 1, 1, 0); #2;
    chk("lat0 stall_d", 1, 32'(bus1.stall_d), 0);
    chk("lat0 stall_d", 0, 32'(bus0.stall_d), 1);
    tick();

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus1.issue_valid_d = ($urandom_range(0, 9) < 8);
      bus1.rs1_d = 5'($urandom_range(0, 7));
      bus1.rs2_d = 5'($urandom_range(0, 7));
      bus1.use_rs1_d = 1'($urandom);
      bus1.use_rs2_d = 1'($urandom);
      bus1.rd_d = 5'($urandom_range(0, 7));
      bus1.we_d = 1'($urandom);
      bus1.lat_d = 4'($urandom_range(0, 15));
      bus1.long_op_d = ($urandom_range(0, 4) == 0);
      bus1.lou_busy = ($urandom_range(0, 2) == 0);
      bus1.pc_src_e = ($urandom_range(0, 9) == 0);
      bus1.rs1_e = 5'($urandom_range(0, 7));
      bus1.rs2_e = 5'($urandom_range(0, 7));
      bus1.rd_m = 5'($urandom_range(0, 7));
      bus1.rd_w = 5'($urandom_range(0, 7));
      bus1.we_m = 1'($urandom);
      bus1.we_w = 1'($urandom);
      tick();
    end
    rst = 0;
    idle_in();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
